// File: rtl/render_queue_fifo.sv
// render_queue_fifo
//   Avalon-MM slave that stages 48-bit sprite render commands written by the
//   CPU and queues them for the frame-buffer compositor (clk50 domain).
//   Command layout: {magic[7:0], x[15:0], y[15:0], flags[7:0]};
//   magic 8'hFF is the "do render" (frame end) marker.
//
// Ports
//   clk50                  in   system clock
//   reset                  in   synchronous, active-high reset
//   chipselect/write/read  in   Avalon slave strobes
//   address[1:0]           in   Avalon word address
//   writedata[31:0]        in   Avalon write data
//   readdata[31:0]         out  Avalon read data, valid the cycle after read
//   render_queue_dout[47:0] out head command (show-ahead), FF marker when empty
//   render_queue_pop_front in   consumer pop, sampled on posedge clk50
//
// Register map
//   wr 0: stage_xy             rd 0: stage_xy
//   wr 1: push command         rd 1: {16'b0, head magic, head flags}
//   wr 2: -                    rd 2: {16'b0, frame_count, overflow, full, empty, count[4:0]}
//   wr 3: [0] clr overflow,    rd 3: 0
//         [1] clr frame_count
module render_queue_fifo #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [47:0] render_queue_dout,
  input  logic        render_queue_pop_front
);

  localparam logic [AW:0]  DEPTH_C      = (AW+1)'(DEPTH);
  localparam logic [47:0]  EMPTY_MARKER = 48'hFF00_0000_0000;
  localparam logic [7:0]   MAGIC_RENDER = 8'hFF;

  logic [47:0]   mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   stage_xy_q, stage_xy_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic [31:0]   readdata_q, readdata_d;

  logic          wr_en, rd_en;
  logic          push_req, push_ok, pop_ok;
  logic          empty, full;
  logic          frame_inc, frame_dec;
  logic [47:0]   head;
  logic [47:0]   push_cmd;

  always_comb begin
    wr_en    = chipselect & write;
    rd_en    = chipselect & read;
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_C);
    head     = mem_q[rd_ptr_q];
    push_cmd = {writedata[15:8], stage_xy_q, writedata[7:0]};
    push_req = wr_en && (address == 2'd1);
    pop_ok   = render_queue_pop_front && !empty;
    // A push into a full queue still fits when the head leaves in the same cycle.
    push_ok  = push_req && (!full || pop_ok);
    frame_inc = push_ok && (writedata[15:8] == MAGIC_RENDER);
    frame_dec = pop_ok && (head[47:40] == MAGIC_RENDER);
    render_queue_dout = empty ? EMPTY_MARKER : head;
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    stage_xy_d    = stage_xy_q;
    overflow_d    = overflow_q;
    frame_count_d = frame_count_q;
    readdata_d    = readdata_q;

    if (wr_en && (address == 2'd0))
      stage_xy_d = writedata;

    if (push_ok)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)
      rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (push_req && !push_ok)
      overflow_d = 1'b1;

    // Increment saturates at 255; decrement never wraps below zero (can happen
    // after a software clear while frame markers are still queued).
    if (frame_inc && !frame_dec) begin
      if (frame_count_q != 8'hFF)
        frame_count_d = frame_count_q + 8'd1;
    end else if (frame_dec && !frame_inc) begin
      if (frame_count_q != 8'h00)
        frame_count_d = frame_count_q - 8'd1;
    end

    if (wr_en && (address == 2'd3)) begin
      if (writedata[0])
        overflow_d = 1'b0;
      if (writedata[1])
        frame_count_d = '0;
    end

    // Read data is built from current (pre-write) state.
    if (rd_en) begin
      case (address)
        2'd0:    readdata_d = stage_xy_q;
        2'd1:    readdata_d = {16'b0, render_queue_dout[47:40], render_queue_dout[7:0]};
        2'd2:    readdata_d = {16'b0, frame_count_q, overflow_q, full, empty, count_q[4:0]};
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      stage_xy_q    <= '0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
      readdata_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      stage_xy_q    <= stage_xy_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
      readdata_q    <= readdata_d;
    end
  end

  // Storage is not reset: an entry is only visible once count covers it.
  always_ff @(posedge clk50) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= push_cmd;
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_render_queue_fifo.sv
module tb_render_queue_fifo;

  logic        clk50 = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [1:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [47:0] render_queue_dout;
  logic        render_queue_pop_front = 1'b0;

  int total = 0;
  int bad   = 0;

  localparam logic [47:0] MARKER = 48'hFF00_0000_0000;
  localparam logic [31:0] STAGE  = 32'h1234_5678;

  render_queue_fifo #(.DEPTH(32), .AW(5)) dut (
    .clk50                  (clk50),
    .reset                  (reset),
    .chipselect             (chipselect),
    .write                  (write),
    .read                   (read),
    .address                (address),
    .writedata              (writedata),
    .readdata               (readdata),
    .render_queue_dout      (render_queue_dout),
    .render_queue_pop_front (render_queue_pop_front)
  );

  always #5 clk50 = ~clk50;

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk50);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk50);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk50);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk50);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic pop();
    @(negedge clk50);
    render_queue_pop_front = 1'b1;
    @(negedge clk50);
    render_queue_pop_front = 1'b0;
  endtask

  task automatic push_magic(input logic [7:0] m, input logic [7:0] f);
    wr(2'd1, {16'h0, m, f});
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (2) @(negedge clk50);
    reset = 1'b0;
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0020) begin bad++; $display("FAIL reset_status got=%h exp=%h", d, 32'h20); end
    total++;
    if (render_queue_dout !== MARKER) begin bad++; $display("FAIL reset_dout got=%h exp=%h", render_queue_dout, MARKER); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    wr(2'd0, 32'h0140_00F0);
    wr(2'd1, 32'h0000_0201);
    total++;
    if (render_queue_dout !== 48'h02_0140_00F0_01) begin bad++; $display("FAIL single_dout got=%h exp=%h", render_queue_dout, 48'h02_0140_00F0_01); end
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0001) begin bad++; $display("FAIL single_status got=%h exp=%h", d, 32'h1); end
    rd(2'd1, d);
    total++;
    if (d !== 32'h0000_0201) begin bad++; $display("FAIL single_head got=%h exp=%h", d, 32'h201); end
    rd(2'd0, d);
    total++;
    if (d !== 32'h0140_00F0) begin bad++; $display("FAIL single_stage got=%h exp=%h", d, 32'h014000F0); end
    pop();
    total++;
    if (render_queue_dout !== MARKER) begin bad++; $display("FAIL single_pop_dout got=%h exp=%h", render_queue_dout, MARKER); end
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0020) begin bad++; $display("FAIL single_pop_status got=%h exp=%h", d, 32'h20); end
  endtask

  task automatic test_fill_overflow();
    logic [31:0] d;
    logic [7:0]  m;
    logic [47:0] e;
    wr(2'd0, STAGE);
    for (int i = 0; i < 32; i++) begin
      m = 8'(i);
      push_magic(m, 8'hA5);
    end
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0040) begin bad++; $display("FAIL fill_full got=%h exp=%h", d, 32'h40); end
    push_magic(8'h55, 8'h00);
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_00C0) begin bad++; $display("FAIL fill_overflow got=%h exp=%h", d, 32'hC0); end
    for (int i = 0; i < 32; i++) begin
      m = 8'(i);
      e = {m, STAGE, 8'hA5};
      total++;
      if (render_queue_dout !== e) begin bad++; $display("FAIL fill_order[%0d] got=%h exp=%h", i, render_queue_dout, e); end
      pop();
    end
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_00A0) begin bad++; $display("FAIL drain_status got=%h exp=%h", d, 32'hA0); end
    wr(2'd3, 32'h1);
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0020) begin bad++; $display("FAIL ovf_clear got=%h exp=%h", d, 32'h20); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    logic [7:0]  m;
    logic [47:0] e;
    for (int i = 0; i < 32; i++) begin
      m = 8'(i + 8'h40);
      push_magic(m, 8'h00);
    end
    @(negedge clk50);
    chipselect = 1'b1; write = 1'b1; address = 2'd1; writedata = 32'h0000_9907;
    render_queue_pop_front = 1'b1;
    @(negedge clk50);
    chipselect = 1'b0; write = 1'b0; render_queue_pop_front = 1'b0;
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0040) begin bad++; $display("FAIL fullpp_status got=%h exp=%h", d, 32'h40); end
    for (int i = 1; i < 32; i++) begin
      m = 8'(i + 8'h40);
      e = {m, STAGE, 8'h00};
      total++;
      if (render_queue_dout !== e) begin bad++; $display("FAIL fullpp_order[%0d] got=%h exp=%h", i, render_queue_dout, e); end
      pop();
    end
    e = {8'h99, STAGE, 8'h07};
    total++;
    if (render_queue_dout !== e) begin bad++; $display("FAIL fullpp_last got=%h exp=%h", render_queue_dout, e); end
    pop();
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0020) begin bad++; $display("FAIL fullpp_empty got=%h exp=%h", d, 32'h20); end
  endtask

  task automatic test_frame_count();
    logic [31:0] d;
    push_magic(8'h01, 8'h00);
    push_magic(8'h02, 8'h00);
    push_magic(8'h03, 8'h00);
    push_magic(8'hFF, 8'h00);
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0104) begin bad++; $display("FAIL frame_inc got=%h exp=%h", d, 32'h104); end
    repeat (4) pop();
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0020) begin bad++; $display("FAIL frame_dec got=%h exp=%h", d, 32'h20); end
    pop();
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0020) begin bad++; $display("FAIL empty_pop got=%h exp=%h", d, 32'h20); end
    total++;
    if (render_queue_dout !== MARKER) begin bad++; $display("FAIL empty_pop_dout got=%h exp=%h", render_queue_dout, MARKER); end
    push_magic(8'hFF, 8'h00);
    push_magic(8'hFF, 8'h00);
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0202) begin bad++; $display("FAIL frame_two got=%h exp=%h", d, 32'h202); end
    wr(2'd3, 32'h2);
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0002) begin bad++; $display("FAIL frame_clear got=%h exp=%h", d, 32'h2); end
    repeat (2) pop();
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0020) begin bad++; $display("FAIL frame_floor got=%h exp=%h", d, 32'h20); end
  endtask

  task automatic test_rw_same_addr();
    logic [31:0] d;
    @(negedge clk50);
    chipselect = 1'b1; write = 1'b1; read = 1'b1; address = 2'd0; writedata = 32'hCAFE_F00D;
    @(negedge clk50);
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    total++;
    if (readdata !== STAGE) begin bad++; $display("FAIL rw_old got=%h exp=%h", readdata, STAGE); end
    rd(2'd0, d);
    total++;
    if (d !== 32'hCAFE_F00D) begin bad++; $display("FAIL rw_new got=%h exp=%h", d, 32'hCAFEF00D); end
    rd(2'd3, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL addr3_read got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) push_magic(8'h10, 8'h00);
    @(negedge clk50);
    reset = 1'b1;
    @(negedge clk50);
    reset = 1'b0;
    total++;
    if (render_queue_dout !== MARKER) begin bad++; $display("FAIL midreset_dout got=%h exp=%h", render_queue_dout, MARKER); end
    rd(2'd2, d);
    total++;
    if (d !== 32'h0000_0020) begin bad++; $display("FAIL midreset_status got=%h exp=%h", d, 32'h20); end
    rd(2'd0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL midreset_stage got=%h exp=%h", d, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_frame_count();
    test_rw_same_addr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
